// File: rtl/stream_max_pkg.sv
// Shared defaults for the attention-datapath reducers (stream and parallel Min/Max).
package stream_max_pkg;
    localparam int SM_DATA_WIDTH  = 16;
    localparam int SM_DATA_LENGTH = 8;
endpackage

// File: rtl/stream_max_if.sv
// Element stream in, row max/argmax result out; both sides are valid/ready.
interface stream_max_if
    import stream_max_pkg::*;
#(
    parameter int DATA_WIDTH  = SM_DATA_WIDTH,
    parameter int DATA_LENGTH = SM_DATA_LENGTH
);
    localparam int IDX_WIDTH = $clog2(DATA_LENGTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_max;
    logic [IDX_WIDTH-1:0]  out_idx;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_idx
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_idx
    );
endinterface

// File: rtl/stream_max.sv
// Serial signed max/argmax over DATA_LENGTH elements; ties keep the earliest index.
module stream_max
    import stream_max_pkg::*;
#(
    parameter int DATA_WIDTH  = SM_DATA_WIDTH,
    parameter int DATA_LENGTH = SM_DATA_LENGTH
) (
    input  logic         clk,
    input  logic         rst_n,
    stream_max_if.slave  s_if
);
    localparam int IDX_WIDTH = $clog2(DATA_LENGTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_LENGTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          r_in_ready;
    logic                          r_out_valid;
    logic                          w_in_ready_nxt;
    logic                          w_out_valid_nxt;
    logic [IDX_WIDTH-1:0]          r_cnt;
    logic [IDX_WIDTH-1:0]          r_idx;
    logic signed [DATA_WIDTH-1:0]  r_max;
    logic                          w_in_acc;
    logic                          w_out_acc;
    logic                          w_last;

    assign w_in_acc  = s_if.in_valid && r_in_ready;
    assign w_out_acc = r_out_valid && s_if.out_ready;
    assign w_last    = (r_cnt == LAST_IDX);

    // Handshake flags are flopped from the next state, so neither depends
    // combinationally on in_valid/out_ready of the current cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COLLECT;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_in_acc && w_last) w_state_nxt = OUTPUT;
            OUTPUT:  if (w_out_acc)          w_state_nxt = COLLECT;
            default:                         w_state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        w_in_ready_nxt  = (w_state_nxt == COLLECT);
        w_out_valid_nxt = (w_state_nxt == OUTPUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_max <= '0;
        end else if (w_in_acc) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (r_cnt == '0) begin
                r_max <= s_if.in_data;
                r_idx <= '0;
            end else if ($signed(s_if.in_data) > r_max) begin
                r_max <= s_if.in_data;
                r_idx <= r_cnt;
            end
        end
    end

    assign s_if.in_ready  = r_in_ready;
    assign s_if.out_valid = r_out_valid;
    assign s_if.out_max   = r_max;
    assign s_if.out_idx   = r_idx;
endmodule

// File: tb/tb_stream_max.sv
// Directed scenarios for stream_max with hand-computed row results.
module tb_stream_max;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    stream_max_if #(.DATA_WIDTH(16), .DATA_LENGTH(8)) bif ();

    stream_max #(.DATA_WIDTH(16), .DATA_LENGTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_if  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Present one element and return 1 time unit after the edge that accepts it.
    task automatic push(input logic [15:0] d);
        int n;
        n = 0;
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        while (bif.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (bif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b required 1", bif.in_ready);
        end else begin
            @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bif.in_valid = 1'b1;
        bif.in_data  = 16'h1234;
        bif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", bif.in_ready); end
        n_checks++;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bif.out_valid); end
        n_checks++;
        if (bif.out_max !== 16'h0000) begin n_fail++; $display("FAIL reset_out_max: got %h required 0000", bif.out_max); end
        n_checks++;
        if (bif.out_idx !== 3'd0) begin n_fail++; $display("FAIL reset_out_idx: got %0d required 0", bif.out_idx); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_early: got %b required 0", bif.in_ready); end
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        n_checks++;
        if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b required 1", bif.in_ready); end
        n_checks++;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b required 0", bif.out_valid); end
    endtask

    task automatic test_back_to_back_tie();
        logic [15:0] v [8];
        v = '{16'h0003, 16'hFFFF, 16'h0007, 16'h0002, 16'h0007, 16'h0000, 16'hFFFB, 16'h0001};
        bif.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) push(v[i]);
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL tie_before_last: out_valid=%b in_ready=%b required 0/1", bif.out_valid, bif.in_ready);
        end
        push(v[7]);
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL tie_after_last: out_valid=%b in_ready=%b required 1/0", bif.out_valid, bif.in_ready);
        end
        n_checks++;
        if (bif.out_max !== 16'h0007) begin n_fail++; $display("FAIL tie_max: got %h required 0007", bif.out_max); end
        n_checks++;
        if (bif.out_idx !== 3'd2) begin n_fail++; $display("FAIL tie_idx: got %0d required 2", bif.out_idx); end
        @(posedge clk); #1;
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL tie_drain: out_valid=%b in_ready=%b required 0/1", bif.out_valid, bif.in_ready);
        end
    endtask

    task automatic test_all_negative();
        logic [15:0] v [8];
        v = '{16'hFF9C, 16'hFFFD, 16'hFFCE, 16'hFFFD, 16'hFFF9, 16'hFFF8, 16'hFFF7, 16'hFF38};
        for (int i = 0; i < 8; i++) push(v[i]);
        n_checks++;
        if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL neg_valid: got %b required 1", bif.out_valid); end
        n_checks++;
        if (bif.out_max !== 16'hFFFD) begin n_fail++; $display("FAIL neg_max: got %h required FFFD", bif.out_max); end
        n_checks++;
        if (bif.out_idx !== 3'd1) begin n_fail++; $display("FAIL neg_idx: got %0d required 1", bif.out_idx); end
        @(posedge clk); #1;
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL neg_drain: out_valid=%b in_ready=%b required 0/1", bif.out_valid, bif.in_ready);
        end
    endtask

    task automatic test_extremes_bubbles();
        logic [15:0] v [8];
        v = '{16'h8000, 16'hFFFF, 16'h0005, 16'h1000, 16'h7FFE, 16'h0000, 16'h7FFE, 16'h7FFF};
        for (int i = 0; i < 8; i++) begin
            push(v[i]);
            if (i < 7) begin
                repeat (2) @(posedge clk);
                #1;
            end
            if (i == 6) begin
                n_checks++;
                if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_early_valid: got %b required 0", bif.out_valid); end
            end
        end
        n_checks++;
        if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL bubble_valid: got %b required 1", bif.out_valid); end
        n_checks++;
        if (bif.out_max !== 16'h7FFF) begin n_fail++; $display("FAIL bubble_max: got %h required 7FFF", bif.out_max); end
        n_checks++;
        if (bif.out_idx !== 3'd7) begin n_fail++; $display("FAIL bubble_idx: got %0d required 7", bif.out_idx); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [15:0] a [8];
        logic [15:0] b [8];
        a = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'hFFFF};
        b = '{16'd2, 16'd9, 16'd4, 16'd9, 16'd1, 16'd0, 16'd3, 16'd8};
        bif.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(a[i]);
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.out_max !== 16'h0046 || bif.out_idx !== 3'd6) begin
            n_fail++; $display("FAIL bp_first: valid=%b max=%h idx=%0d required 1/0046/6", bif.out_valid, bif.out_max, bif.out_idx);
        end
        bif.in_valid = 1'b1;
        bif.in_data  = b[0];
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bif.out_valid !== 1'b1 || bif.out_max !== 16'h0046 || bif.out_idx !== 3'd6 || bif.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid=%b max=%h idx=%0d in_ready=%b required 1/0046/6/0",
                         c, bif.out_valid, bif.out_max, bif.out_idx, bif.in_ready);
            end
        end
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", bif.out_valid, bif.in_ready);
        end
        for (int i = 0; i < 8; i++) push(b[i]);
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.out_max !== 16'h0009 || bif.out_idx !== 3'd1) begin
            n_fail++; $display("FAIL bp_next_row: valid=%b max=%h idx=%0d required 1/0009/1", bif.out_valid, bif.out_max, bif.out_idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_row();
        push(16'd100);
        push(16'd200);
        push(16'd300);
        push(16'd400);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bif.in_ready !== 1'b0 || bif.out_valid !== 1'b0 || bif.out_max !== 16'h0000 || bif.out_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: in_ready=%b valid=%b max=%h idx=%0d required 0/0/0000/0",
                     bif.in_ready, bif.out_valid, bif.out_max, bif.out_idx);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) push(16'(i));
        n_checks++;
        if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_valid: got %b required 1", bif.out_valid); end
        n_checks++;
        if (bif.out_max !== 16'h0008) begin n_fail++; $display("FAIL midreset_max: got %h required 0008", bif.out_max); end
        n_checks++;
        if (bif.out_idx !== 3'd7) begin n_fail++; $display("FAIL midreset_idx: got %0d required 7", bif.out_idx); end
        @(posedge clk); #1;
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_drain: out_valid=%b in_ready=%b required 0/1", bif.out_valid, bif.in_ready);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.out_ready = 1'b1;
        test_reset();
        test_back_to_back_tie();
        test_all_negative();
        test_extremes_bubbles();
        test_backpressure();
        test_reset_mid_row();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_max.md
# stream_max

Streaming signed maximum/argmax reducer for the attention datapath. It accepts one DATA_WIDTH element per transfer over a valid/ready input. After DATA_LENGTH elements it presents the row maximum and its index on a valid/ready output. It sits ahead of the softmax stage, supplying the per-row max used for score normalisation, and replaces a fully parallel packed-vector compare when scores arrive serially.

## Interface
- DATA_WIDTH, 16, element width; two's-complement signed.
- DATA_LENGTH, 8, elements per row; must be ≥2.
- IDX_WIDTH, derived localparam = $clog2(DATA_LENGTH), index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream element valid.
- in_ready  output  1  block can accept an element.
- in_data  input  DATA_WIDTH  signed element.
- out_valid  output  1  row result valid.
- out_ready  input  1  downstream accepts the result.
- out_max  output  DATA_WIDTH  signed row maximum.
- out_idx  output  IDX_WIDTH  position (0-based) of the maximum within the row.

## Operation
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- The FSM has two states, COLLECT and OUTPUT. The reset state is COLLECT.
- COLLECT:
  - in_ready = 1 and out_valid = 0.
  - The element counter cnt advances on each input transfer.
  - On transfer with cnt == 0: max_r <= in_data, idx_r <= 0.
  - On transfer with cnt > 0: if $signed(in_data) > $signed(max_r), then max_r <= in_data and idx_r <= cnt. Otherwise both are held.
  - The compare is strictly greater-than, so ties keep the earliest index.
  - On transfer with cnt == DATA_LENGTH-1: cnt <= 0 and the FSM moves to OUTPUT.
- OUTPUT:
  - in_ready = 0 and out_valid = 1.
  - out_max = max_r and out_idx = idx_r. Both stay stable until the output transfer.
  - On output transfer the FSM returns to COLLECT.
- in_valid while in_ready = 0 is ignored. No element is consumed or lost, because upstream must hold it.
- in_ready and out_valid are registered flops, not combinational decodes of the state.
- Reset values:
  - in_ready = 0; it rises on the first clock edge after rst_n deasserts.
  - out_valid = 0, out_max = 0, out_idx = 0, cnt = 0, state = COLLECT.
- Reset mid-row or mid-OUTPUT discards all partial results. Nothing is emitted for the aborted row.

## Timing
- out_valid rises in the cycle after the edge that accepts element DATA_LENGTH-1.
- in_ready rises in the cycle after the output-transfer edge.
- Minimum row period is DATA_LENGTH + 1 cycles: DATA_LENGTH input transfers plus one output cycle with out_ready held high.
- Input bubbles (in_valid low) stall cnt. They do not affect the result.
- Output back-pressure of any length holds OUTPUT, with all outputs frozen and in_ready = 0.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- The shared Verilog header of the attention datapath holds the default DATA_WIDTH and DATA_LENGTH. Both are used here, and the same defaults apply to the parallel Min/Max blocks.
- State encodings are local parameters. They are not shared.
- The block is a single module with no sub-module. The signed compare is one inline expression.

## Test plan
- **Reset:** hold rst_n low for 3 cycles with in_valid = 1.
  - in_ready = 0, out_valid = 0, out_max = 0, out_idx = 0.
  - in_ready = 1 one cycle after release.
- **Back-to-back row with tie:** send 3, −1, 7, 2, 7, 0, −5, 1 with out_ready = 1.
  - out_valid is high in the cycle after the 8th accept.
  - out_max = 16'h0007, out_idx = 2 (the tie keeps index 2).
- **All-negative row:** send −100, −3, −50, −3, −7, −8, −9, −200.
  - out_max = 16'hFFFD, out_idx = 1. This checks the signed compare and tie handling.
- **Extremes with input bubbles:** send 16'h8000 at index 0 and 16'h7FFF at index 7, with in_valid low for 2 cycles between elements.
  - out_max = 16'h7FFF, out_idx = 7.
- **Output back-pressure:** hold out_ready = 0 for 5 cycles after out_valid, with in_valid = 1 throughout.
  - out_valid, out_max and out_idx stay stable, and in_ready stays 0.
  - After out_ready = 1, in_ready = 1 one cycle later, and the next row result is correct.
- **Reset mid-row:** assert rst_n low after 4 accepted elements.
  - All outputs return to reset values.
  - A following full row 1..8 yields out_max = 8, out_idx = 7, unaffected by the aborted data.
